// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register file debug port from FIRST_REG to
// LAST_REG and streams each value, tagged with its index, over valid/ready.
//
// Optional feature: define REG_DUMP_CHECKSUM_EN to append one checksum beat
// (XOR of every dumped value) after the LAST_REG beat.
//
// Ports:
//   clk          rising-edge clock
//   startin      synchronous active-high reset
//   start        one-cycle dump request (honoured only in IDLE)
//   abort        terminates a dump in progress
//   regNo        register index driven to the register file debug port
//   val          register contents returned for regNo
//   out_valid    out_data / out_idx hold a beat
//   out_ready    consumer accepts the beat
//   out_data     dumped value or checksum word
//   out_idx      register index of the beat (0 on the checksum beat)
//   out_last     final beat of the dump
//   out_is_csum  beat is the checksum word
//   busy         high in every state except IDLE
//   done         one-cycle pulse after the final beat is accepted
module reg_dump_reader #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        startin,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  regNo,
    input  logic [31:0] val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        out_is_csum,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_SAMPLE,
        ST_SEND,
`ifdef REG_DUMP_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE
    } state_t;

    state_t state;

    // regNo doubles as the index counter; it only moves when leaving SEND.
    logic at_last;
    assign at_last = (regNo == LAST_IDX);

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_acc;
`else
    assign out_is_csum = 1'b0;
`endif

    // Dump sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (startin) begin
            state     <= ST_IDLE;
            regNo     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            out_is_csum <= 1'b0;
            csum_acc    <= '0;
`endif
        end else if (state != ST_IDLE && abort) begin
            // A beat handshaked this cycle is already delivered; just stop.
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            out_is_csum <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        regNo <= FIRST_IDX;
                        busy  <= 1'b1;
                        state <= ST_ADDR;
`ifdef REG_DUMP_CHECKSUM_EN
                        csum_acc <= '0;
`endif
                    end
                end
                ST_ADDR: begin
                    state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    out_data  <= val;
                    out_idx   <= regNo;
                    out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_acc  <= csum_acc ^ val;
                    out_last  <= 1'b0;
`else
                    out_last  <= at_last;
`endif
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        // Compare before incrementing so LAST_REG=31 never wraps.
                        if (at_last) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            out_data    <= csum_acc;
                            out_idx     <= '0;
                            out_is_csum <= 1'b1;
                            out_last    <= 1'b1;
                            state       <= ST_CSUM;
`else
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
`endif
                        end else begin
                            regNo     <= regNo + IDX_W'(1);
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= ST_ADDR;
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_last    <= 1'b0;
                        out_is_csum <= 1'b0;
                        done        <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: three instances cover the full 0..31
// range, a 5..7 range under heavy backpressure, and the single-register 31 case.
module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int          A_BEATS   = 33;
    localparam int          A_DONE    = 98;
    localparam logic        LAST_ON_REG = 1'b0;
    localparam int          B_BEATS   = 4;
    localparam int          C_BEATS   = 2;
    localparam int          C_DONE    = 5;
`else
    localparam int          A_BEATS   = 32;
    localparam int          A_DONE    = 97;
    localparam logic        LAST_ON_REG = 1'b1;
    localparam int          B_BEATS   = 3;
    localparam int          C_BEATS   = 1;
    localparam int          C_DONE    = 4;
`endif

    logic clk;
    logic startin;

    logic        start_a, abort_a, ready_a, valid_a, last_a, csum_a, busy_a, done_a;
    logic [4:0]  regno_a, idx_a;
    logic [31:0] val_a, data_a;
    logic        start_b, abort_b, ready_b, valid_b, last_b, csum_b, busy_b, done_b;
    logic [4:0]  regno_b, idx_b;
    logic [31:0] val_b, data_b;
    logic        start_c, abort_c, ready_c, valid_c, last_c, csum_c, busy_c, done_c;
    logic [4:0]  regno_c, idx_c;
    logic [31:0] val_c, data_c;

    logic [31:0] rf_a [32];
    logic [31:0] rf_b [32];
    logic [31:0] rf_c [32];

    assign val_a = rf_a[regno_a];
    assign val_b = rf_b[regno_b];
    assign val_c = rf_c[regno_c];

    int n_tests = 0;
    int n_fail  = 0;

    reg_dump_reader u_a (
        .clk(clk), .startin(startin), .start(start_a), .abort(abort_a),
        .regNo(regno_a), .val(val_a), .out_valid(valid_a), .out_ready(ready_a),
        .out_data(data_a), .out_idx(idx_a), .out_last(last_a),
        .out_is_csum(csum_a), .busy(busy_a), .done(done_a)
    );

    reg_dump_reader #(.FIRST_REG(5), .LAST_REG(7)) u_b (
        .clk(clk), .startin(startin), .start(start_b), .abort(abort_b),
        .regNo(regno_b), .val(val_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_data(data_b), .out_idx(idx_b), .out_last(last_b),
        .out_is_csum(csum_b), .busy(busy_b), .done(done_b)
    );

    reg_dump_reader #(.FIRST_REG(31), .LAST_REG(31)) u_c (
        .clk(clk), .startin(startin), .start(start_c), .abort(abort_c),
        .regNo(regno_c), .val(val_c), .out_valid(valid_c), .out_ready(ready_c),
        .out_data(data_c), .out_idx(idx_c), .out_last(last_c),
        .out_is_csum(csum_c), .busy(busy_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_regno"}, 32'(regno_a), 32'd0);
        check({tag, "_valid"}, 32'(valid_a), 32'd0);
        check({tag, "_data"},  data_a,       32'd0);
        check({tag, "_idx"},   32'(idx_a),   32'd0);
        check({tag, "_last"},  32'(last_a),  32'd0);
        check({tag, "_csum"},  32'(csum_a),  32'd0);
        check({tag, "_busy"},  32'(busy_a),  32'd0);
        check({tag, "_done"},  32'(done_a),  32'd0);
    endtask

    // Full 0..31 dump on instance A with out_ready high; optional stray start.
    task automatic run_a(input int extra_start, input string tag);
        int beats;
        int first_v;
        int done_cyc;
        beats = 0; first_v = -1; done_cyc = -1;
        ready_a = 1'b1;
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            tick();
            start_a = (cyc == extra_start);
            if (cyc == 1) check({tag, "_busy_up"}, 32'(busy_a), 32'd1);
            if (valid_a && first_v < 0) first_v = cyc;
            if (valid_a && ready_a) begin
                if (beats < 32) begin
                    check({tag, "_idx"},  32'(idx_a), 32'(beats));
                    check({tag, "_data"}, data_a, 32'h100 + 32'(beats));
                    check({tag, "_cs0"},  32'(csum_a), 32'd0);
                    if (beats == 31) check({tag, "_last31"}, 32'(last_a), 32'(LAST_ON_REG));
                    else             check({tag, "_last"},   32'(last_a), 32'd0);
                end else begin
                    check({tag, "_csum_flag"}, 32'(csum_a), 32'd1);
                    check({tag, "_csum_data"}, data_a, 32'h0000_0000);
                    check({tag, "_csum_idx"},  32'(idx_a), 32'd0);
                    check({tag, "_csum_last"}, 32'(last_a), 32'd1);
                end
                beats++;
            end
            if (done_a && done_cyc < 0) done_cyc = cyc;
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                check({tag, "_busy_down"}, 32'(busy_a), 32'd0);
                check({tag, "_done_pulse"}, 32'(done_a), 32'd0);
                break;
            end
        end
        check({tag, "_first_valid"}, 32'(first_v), 32'd3);
        check({tag, "_beats"}, 32'(beats), 32'(A_BEATS));
        check({tag, "_done_cyc"}, 32'(done_cyc), 32'(A_DONE));
    endtask

    initial begin
        int beats;
        int guard;
        int done_cyc;
        logic [31:0] hold_d;
        logic [4:0]  hold_i, hold_r;
        logic        hold_l;
        logic [31:0] exp_d;
        logic [4:0]  exp_i;
        logic        exp_l, exp_c;
        bit          seen;

        for (int i = 0; i < 32; i++) begin
            rf_a[i] = 32'h100 + 32'(i);
            rf_b[i] = 32'h0;
            rf_c[i] = 32'h0;
        end
        rf_b[5]  = 32'hDEAD_BEEF;
        rf_b[6]  = 32'h0000_0001;
        rf_b[7]  = 32'hFFFF_FFFF;
        rf_c[31] = 32'hCAFE_0031;

        {start_a, abort_a, ready_a} = '0;
        {start_b, abort_b, ready_b} = '0;
        {start_c, abort_c, ready_c} = '0;
        startin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        startin = 1'b0;
        check_reset_a("rst");
        check("rst_b_busy", 32'(busy_b), 32'd0);

        // Full-range dump.
        run_a(0, "full");

        // Range 5..7, out_ready held low 4 cycles on every beat.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        beats = 0;
        guard = 0;
        while (beats < B_BEATS && guard < 200) begin
            guard++;
            if (valid_b) begin
                case (beats)
                    0: begin exp_i = 5'd5; exp_d = 32'hDEAD_BEEF; exp_l = 1'b0; exp_c = 1'b0; end
                    1: begin exp_i = 5'd6; exp_d = 32'h0000_0001; exp_l = 1'b0; exp_c = 1'b0; end
                    2: begin exp_i = 5'd7; exp_d = 32'hFFFF_FFFF; exp_l = LAST_ON_REG; exp_c = 1'b0; end
                    default: begin exp_i = 5'd0; exp_d = 32'h2152_4111; exp_l = 1'b1; exp_c = 1'b1; end
                endcase
                check("b_idx",  32'(idx_b),  32'(exp_i));
                check("b_data", data_b,      exp_d);
                check("b_last", 32'(last_b), 32'(exp_l));
                check("b_csum", 32'(csum_b), 32'(exp_c));
                hold_d = data_b; hold_i = idx_b; hold_r = regno_b; hold_l = last_b;
                repeat (4) begin
                    tick();
                    check("b_stall_valid", 32'(valid_b), 32'd1);
                    check("b_stall_data",  data_b, hold_d);
                    check("b_stall_idx",   32'(idx_b), 32'(hold_i));
                    check("b_stall_last",  32'(last_b), 32'(hold_l));
                    check("b_stall_regno", 32'(regno_b), 32'(hold_r));
                end
                ready_b = 1'b1;
                tick();
                ready_b = 1'b0;
                beats++;
            end else begin
                tick();
            end
        end
        check("b_beats", 32'(beats), 32'(B_BEATS));
        check("b_done", 32'(done_b), 32'd1);
        check("b_valid_after", 32'(valid_b), 32'd0);
        tick();
        check("b_done_clear", 32'(done_b), 32'd0);
        check("b_busy_down", 32'(busy_b), 32'd0);

        // Single register 31: no wrap to index 0.
        ready_c = 1'b1;
        start_c = 1'b1;
        beats = 0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            start_c = 1'b0;
            if (valid_c && ready_c) begin
                if (!csum_c) begin
                    check("c_idx",  32'(idx_c), 32'd31);
                    check("c_data", data_c, 32'hCAFE_0031);
                    check("c_last", 32'(last_c), 32'(LAST_ON_REG));
                    check("c_cyc",  32'(cyc), 32'd3);
                end else begin
                    check("c_csum_data", data_c, 32'hCAFE_0031);
                    check("c_csum_last", 32'(last_c), 32'd1);
                end
                beats++;
            end
            if (done_c && done_cyc < 0) done_cyc = cyc;
        end
        check("c_beats", 32'(beats), 32'(C_BEATS));
        check("c_done_cyc", 32'(done_cyc), 32'(C_DONE));
        check("c_regno", 32'(regno_c), 32'd31);

        // Abort while idx 10 is stalled.
        ready_a = 1'b1;
        start_a = 1'b1;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 100 && !seen; cyc++) begin
            tick();
            start_a = 1'b0;
            if (valid_a && idx_a == 5'd10) begin
                ready_a = 1'b0;
                seen = 1'b1;
            end
        end
        check("ab_reach10", 32'(seen), 32'd1);
        tick();
        check("ab_stall_valid", 32'(valid_a), 32'd1);
        check("ab_stall_idx", 32'(idx_a), 32'd10);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("ab_valid", 32'(valid_a), 32'd0);
        check("ab_busy",  32'(busy_a),  32'd0);
        check("ab_done",  32'(done_a),  32'd0);
        tick();
        check("ab_done_later", 32'(done_a), 32'd0);

        // Restart after abort begins at index 0.
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (2) tick();
        check("rs_valid", 32'(valid_a), 32'd1);
        check("rs_idx",   32'(idx_a),   32'd0);
        check("rs_data",  data_a,       32'h100);

        // Reset mid-dump.
        repeat (20) tick();
        check("mid_busy", 32'(busy_a), 32'd1);
        startin = 1'b1;
        tick();
        startin = 1'b0;
        check_reset_a("midrst");

        // start+abort together in IDLE: abort wins.
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        check("sa_busy", 32'(busy_a), 32'd0);
        repeat (3) tick();
        check("sa_valid", 32'(valid_a), 32'd0);
        check("sa_busy_later", 32'(busy_a), 32'd0);

        // start while busy is ignored: the dump runs exactly as a clean one.
        run_a(5, "busy_start");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
